// File: rtl/aes_ahb_pkg.sv
// Shared constants, register map decode and types for the AES AHB-Lite register interface.
package aes_ahb_pkg;

  localparam logic [7:0] OFF_TEXT0  = 8'h20;
  localparam logic [7:0] OFF_CTRL   = 8'h30;
  localparam logic [7:0] OFF_STATUS = 8'h34;
  localparam logic [7:0] OFF_CIPH0  = 8'h38;
  localparam logic [7:0] OFF_CIPH3  = 8'h44;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;

  localparam int         HTRANS_ACTIVE_BIT = 1;
  localparam logic       HRESP_OKAY        = 1'b0;
  localparam logic       HRESP_ERROR       = 1'b1;
  localparam logic [2:0] HSIZE_WORD        = 3'b010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_KEY,
    REG_TEXT,
    REG_CTRL,
    REG_STATUS,
    REG_CIPH
  } reg_region_e;

  typedef struct packed {
    reg_region_e region;
    logic [2:0]  idx;
  } reg_sel_t;

  // Map a byte offset to a register region and word index; unaligned or absent words give REG_NONE.
  function automatic reg_sel_t decode_offset(input logic [7:0] off, input int key_words);
    reg_sel_t sel;
    sel.region = REG_NONE;
    sel.idx    = off[4:2];
    if (off[1:0] != 2'b00) begin
      sel.region = REG_NONE;
    end else if (off < OFF_TEXT0) begin
      sel.region = (int'(off[4:2]) < key_words) ? REG_KEY : REG_NONE;
    end else if (off < OFF_CTRL) begin
      sel.region = REG_TEXT;
      sel.idx    = {1'b0, off[3:2]};
    end else if (off == OFF_CTRL) begin
      sel.region = REG_CTRL;
    end else if (off == OFF_STATUS) begin
      sel.region = REG_STATUS;
    end else if ((off >= OFF_CIPH0) && (off <= OFF_CIPH3)) begin
      sel.region = REG_CIPH;
      sel.idx    = {1'b0, off[3:2] + 2'd2};
    end else begin
      sel.region = REG_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/aes_ahb_regif_if.sv
// AHB-Lite slave-side bundle used by the AES register interface.
interface aes_ahb_regif_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/aes_ahb_err_resp.sv
// Two-cycle AHB ERROR sequencer: stall with ERROR, then complete with ERROR.
module aes_ahb_err_resp
  import aes_ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic err_req,
  output logic hready_out,
  output logic hresp,
  output logic err_second
);

  logic err2_r;

  // Remember that the stalled first ERROR cycle has been shown
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err2_r <= 1'b0;
    end else begin
      err2_r <= err_req & ~err2_r;
    end
  end

  // Response outputs for the current data phase
  always_comb begin
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    if (err2_r) begin
      hready_out = 1'b1;
      hresp      = HRESP_ERROR;
    end else if (err_req) begin
      hready_out = 1'b0;
      hresp      = HRESP_ERROR;
    end else begin
      hready_out = 1'b1;
      hresp      = HRESP_OKAY;
    end
  end

  assign err_second = err2_r;

endmodule

// File: rtl/aes_ahb_regif.sv
// AHB-Lite register interface for the AES core: key/text/ciphertext registers, start/done FSM and IRQ.
module aes_ahb_regif
  import aes_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          KEY_WORDS = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  aes_ahb_regif_if.slave          ahb,
  output logic                    irq,
  output logic [32*KEY_WORDS-1:0] aes_key,
  output logic [127:0]            aes_plaintext,
  output logic                    aes_start,
  input  logic                    aes_done,
  input  logic [127:0]            aes_ciphertext
);

  logic        addr_valid_s;
  logic [7:0]  addr_off_s;
  logic        unused_addr_s;
  logic        dp_valid_r;
  logic        dp_write_r;
  logic        dp_size_ok_r;
  logic [7:0]  dp_off_r;
  reg_sel_t    dp_sel_s;
  logic        err_s;
  logic        err_second_s;
  logic        wr_en_s;
  logic        rd_en_s;
  logic        start_s;
  logic        capture_s;
  logic [0:0]  state_r;
  logic        busy_s;
  logic        aes_start_r;
  logic        irq_en_r;
  logic        irq_en_nxt_s;
  logic        done_r;
  logic        done_nxt_s;
  logic        irq_r;
  logic [31:0] rdata_s;
  logic [31:0] key_r  [KEY_WORDS];
  logic [31:0] text_r [4];
  logic [31:0] ciph_r [4];

  assign addr_valid_s  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[HTRANS_ACTIVE_BIT];
  assign addr_off_s    = ahb.HADDR[7:0] - BASE_ADDR[7:0];
  assign unused_addr_s = ^{ahb.HADDR[31:8], ahb.HTRANS[0]};
  assign dp_sel_s      = decode_offset(dp_off_r, KEY_WORDS);
  assign busy_s        = (state_r == ST_BUSY);

  // Address phase capture; held while the bus is stalled
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_r   <= 1'b0;
      dp_write_r   <= 1'b0;
      dp_size_ok_r <= 1'b0;
      dp_off_r     <= 8'h00;
    end else if (ahb.HREADY) begin
      dp_valid_r   <= addr_valid_s;
      dp_write_r   <= ahb.HWRITE;
      dp_size_ok_r <= (ahb.HSIZE == HSIZE_WORD);
      dp_off_r     <= addr_off_s;
    end
  end

  // Error check is done in the data phase so busy and the start bit are seen as they are now
  always_comb begin
    err_s = 1'b0;
    if (!dp_valid_r) begin
      err_s = 1'b0;
    end else if (!dp_size_ok_r || (dp_sel_s.region == REG_NONE)) begin
      err_s = 1'b1;
    end else if (dp_write_r) begin
      case (dp_sel_s.region)
        REG_CIPH:           err_s = 1'b1;
        REG_KEY, REG_TEXT:  err_s = busy_s;
        REG_CTRL:           err_s = busy_s & ahb.HWDATA[CTRL_START_BIT];
        default:            err_s = 1'b0;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  aes_ahb_err_resp u_err_resp (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .err_req    (err_s),
    .hready_out (ahb.HREADYOUT),
    .hresp      (ahb.HRESP),
    .err_second (err_second_s)
  );

  assign wr_en_s   = dp_valid_r & dp_write_r & ~err_s & ~err_second_s;
  assign rd_en_s   = dp_valid_r & ~dp_write_r & ~err_s & ~err_second_s;
  assign start_s   = wr_en_s & (dp_sel_s.region == REG_CTRL) & ahb.HWDATA[CTRL_START_BIT];
  assign capture_s = busy_s & aes_done;

  // Control FSM and start pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      aes_start_r <= 1'b0;
    end else begin
      aes_start_r <= start_s;
      case (state_r)
        ST_IDLE: if (start_s)  state_r <= ST_BUSY;
        ST_BUSY: if (aes_done) state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky done (a new capture beats a same-cycle clear) and irq enable
  always_comb begin
    done_nxt_s   = done_r;
    irq_en_nxt_s = irq_en_r;
    if (capture_s) begin
      done_nxt_s = 1'b1;
    end else if (wr_en_s && (dp_sel_s.region == REG_STATUS) && ahb.HWDATA[STAT_DONE_BIT]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (wr_en_s && (dp_sel_s.region == REG_CTRL)) begin
      irq_en_nxt_s = ahb.HWDATA[CTRL_IRQ_EN_BIT];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
  end

  // Register file updates
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < KEY_WORDS; i++) key_r[i] <= 32'h0;
      for (int i = 0; i < 4; i++) begin
        text_r[i] <= 32'h0;
        ciph_r[i] <= 32'h0;
      end
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_en_s && (dp_sel_s.region == REG_KEY)) begin
        for (int i = 0; i < KEY_WORDS; i++) begin
          if (dp_sel_s.idx == i[2:0]) key_r[i] <= ahb.HWDATA;
        end
      end
      if (wr_en_s && (dp_sel_s.region == REG_TEXT)) begin
        text_r[dp_sel_s.idx[1:0]] <= ahb.HWDATA;
      end
      if (capture_s) begin
        for (int i = 0; i < 4; i++) ciph_r[i] <= aes_ciphertext[32*i +: 32];
      end
      irq_en_r <= irq_en_nxt_s;
      done_r   <= done_nxt_s;
      irq_r    <= done_nxt_s & irq_en_nxt_s;
    end
  end

  // Read data mux, zero outside an accepted read data phase
  always_comb begin
    rdata_s = 32'h0;
    if (rd_en_s) begin
      case (dp_sel_s.region)
        REG_KEY: begin
          for (int i = 0; i < KEY_WORDS; i++) begin
            if (dp_sel_s.idx == i[2:0]) rdata_s = key_r[i];
          end
        end
        REG_TEXT:   rdata_s = text_r[dp_sel_s.idx[1:0]];
        REG_CTRL:   rdata_s[CTRL_IRQ_EN_BIT] = irq_en_r;
        REG_STATUS: begin
          rdata_s[STAT_BUSY_BIT] = busy_s;
          rdata_s[STAT_DONE_BIT] = done_r;
        end
        REG_CIPH:   rdata_s = ciph_r[dp_sel_s.idx[1:0]];
        default:    rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign ahb.HRDATA = rdata_s;
  assign aes_start  = aes_start_r;
  assign irq        = irq_r;

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign aes_key[32*g +: 32] = key_r[g];
  end
  for (genvar g = 0; g < 4; g++) begin : g_text
    assign aes_plaintext[32*g +: 32] = text_r[g];
  end

endmodule

// File: tb/tb_aes_ahb_regif.sv
// Self-checking bench: two interface instances (4- and 8-word keys) against a behavioural register model.
module tb_aes_ahb_regif;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        hsel, sel8, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready;
  logic        aes_done;
  logic [127:0] aes_ciphertext;
  logic        irq4, irq8, start4, start8;
  logic [127:0] key4, pt4, pt8;
  logic [255:0] key8;
  logic        resp_s;
  logic [31:0] rdata_s;

  aes_ahb_regif_if bus4 ();
  aes_ahb_regif_if bus8 ();

  assign hready      = bus4.HREADYOUT & bus8.HREADYOUT;
  assign bus4.HSEL   = hsel & ~sel8;
  assign bus8.HSEL   = hsel & sel8;
  assign bus4.HADDR  = haddr;   assign bus8.HADDR  = haddr;
  assign bus4.HTRANS = htrans;  assign bus8.HTRANS = htrans;
  assign bus4.HWRITE = hwrite;  assign bus8.HWRITE = hwrite;
  assign bus4.HSIZE  = hsize;   assign bus8.HSIZE  = hsize;
  assign bus4.HREADY = hready;  assign bus8.HREADY = hready;
  assign bus4.HWDATA = hwdata;  assign bus8.HWDATA = hwdata;
  assign resp_s  = sel8 ? bus8.HRESP  : bus4.HRESP;
  assign rdata_s = sel8 ? bus8.HRDATA : bus4.HRDATA;

  aes_ahb_regif #(.BASE_ADDR(BASE), .KEY_WORDS(4)) dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus4.slave), .irq(irq4), .aes_key(key4),
    .aes_plaintext(pt4), .aes_start(start4), .aes_done(aes_done), .aes_ciphertext(aes_ciphertext));

  aes_ahb_regif #(.BASE_ADDR(BASE), .KEY_WORDS(8)) dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus8.slave), .irq(irq8), .aes_key(key8),
    .aes_plaintext(pt8), .aes_start(start8), .aes_done(aes_done), .aes_ciphertext(aes_ciphertext));

  // Behavioural model: index 0 = 4-word-key instance, 1 = 8-word-key instance
  int          kw [2] = '{4, 8};
  logic [31:0] m_key  [2][8];
  logic [31:0] m_text [2][4];
  logic [31:0] m_ciph [2][4];
  bit          m_busy [2];
  bit          m_done [2];
  bit          m_irq_en [2];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 8; w++) m_key[d][w] = 32'h0;
      for (int w = 0; w < 4; w++) begin m_text[d][w] = 32'h0; m_ciph[d][w] = 32'h0; end
      m_busy[d] = 1'b0; m_done[d] = 1'b0; m_irq_en[d] = 1'b0;
    end
  endtask

  task automatic model_access(input int d, input bit wr, input int off, input logic [2:0] size,
                              input logic [31:0] wd, output bit e_err, output logic [31:0] e_rd);
    e_err = 1'b0;
    e_rd  = 32'h0;
    if ((off % 4) != 0 || size != 3'b010) e_err = 1'b1;
    else if (off < 32) begin
      if (off / 4 >= kw[d]) e_err = 1'b1;
      else if (!wr) e_rd = m_key[d][off / 4];
      else if (m_busy[d]) e_err = 1'b1;
      else m_key[d][off / 4] = wd;
    end else if (off < 48) begin
      if (!wr) e_rd = m_text[d][(off - 32) / 4];
      else if (m_busy[d]) e_err = 1'b1;
      else m_text[d][(off - 32) / 4] = wd;
    end else if (off == 48) begin
      if (!wr) e_rd = m_irq_en[d] ? 32'h2 : 32'h0;
      else if (m_busy[d] && wd[0]) e_err = 1'b1;
      else begin
        m_irq_en[d] = wd[1];
        if (wd[0]) m_busy[d] = 1'b1;
      end
    end else if (off == 52) begin
      if (!wr) e_rd = 32'(m_done[d]) * 2 + 32'(m_busy[d]);
      else if (wd[1]) m_done[d] = 1'b0;
    end else if (off >= 56 && off <= 68) begin
      if (wr) e_err = 1'b1;
      else e_rd = m_ciph[d][(off - 56) / 4];
    end else e_err = 1'b1;
  endtask

  function automatic logic [255:0] exp_key(input int d);
    logic [255:0] k = '0;
    for (int w = 0; w < kw[d]; w++) k[32*w +: 32] = m_key[d][w];
    return k;
  endfunction

  function automatic logic [127:0] exp_pt(input int d);
    logic [127:0] p = '0;
    for (int w = 0; w < 4; w++) p[32*w +: 32] = m_text[d][w];
    return p;
  endfunction

  task automatic xfer(input bit s8, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rd, output logic r0,
                      output logic r1, output int waits);
    logic rdy;
    @(posedge HCLK); #1;
    sel8 = s8; hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0;
    @(negedge HCLK);
    r0 = resp_s; r1 = resp_s; rdy = hready; rd = rdata_s;
    while (!rdy && waits < 4) begin
      @(negedge HCLK);
      waits++;
      rdy = hready; r1 = resp_s; rd = rd | rdata_s;
    end
    if (!rdy) chk("bus_timeout", {255'b0, rdy}, 256'h1);
  endtask

  task automatic access(input bit s8, input bit wr, input int off, input logic [2:0] size,
                        input logic [31:0] wd);
    bit e_err; logic [31:0] e_rd, rd; logic r0, r1; int w; string tag;
    model_access(s8 ? 1 : 0, wr, off, size, wd, e_err, e_rd);
    xfer(s8, wr, BASE + 32'(off), size, wd, rd, r0, r1, w);
    tag = $sformatf("%s%0d@%02h", wr ? "wr" : "rd", s8 ? 8 : 4, off);
    chk({tag, " waits"}, 256'(w), e_err ? 256'd1 : 256'd0);
    chk({tag, " resp"}, {254'b0, r0, r1}, e_err ? 256'd3 : 256'd0);
    if (!wr || e_err) chk({tag, " rdata"}, 256'(rd), 256'(e_rd));
  endtask

  task automatic pulse_done(input logic [127:0] c);
    @(posedge HCLK); #1;
    aes_done = 1'b1; aes_ciphertext = c;
    @(posedge HCLK); #1;
    aes_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d]) begin
        for (int w = 0; w < 4; w++) m_ciph[d][w] = c[32*w +: 32];
        m_done[d] = 1'b1; m_busy[d] = 1'b0;
      end
    end
    chk("irq4", 256'(irq4), 256'(m_done[0] & m_irq_en[0]));
    chk("irq8", 256'(irq8), 256'(m_done[1] & m_irq_en[1]));
  endtask

  task automatic chk_start(input string tag, input logic exp_first);
    @(negedge HCLK); chk({tag, " start1"}, 256'(start4), 256'(exp_first));
    @(negedge HCLK); chk({tag, " start2"}, 256'(start4), 256'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " start"}, {254'b0, start4, start8}, 256'h0);
    chk({tag, " irq"}, {254'b0, irq4, irq8}, 256'h0);
    chk({tag, " key4"}, 256'(key4), 256'h0);
    chk({tag, " key8"}, key8, 256'h0);
    chk({tag, " pt"}, {pt8, pt4}, 256'h0);
    chk({tag, " hreadyout"}, {254'b0, bus4.HREADYOUT, bus8.HREADYOUT}, 256'h3);
    chk({tag, " hresp"}, {254'b0, bus4.HRESP, bus8.HRESP}, 256'h0);
    chk({tag, " hrdata"}, {bus8.HRDATA, bus4.HRDATA}, 256'h0);
  endtask

  initial begin
    logic [31:0] v, k0;
    logic [127:0] c;
    HRESETn = 1'b0; hsel = 1'b0; sel8 = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0;
    htrans = 2'b00; hsize = 3'b010; aes_done = 1'b0; aes_ciphertext = 128'h0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk_reset_outputs("reset");
    HRESETn = 1'b1;

    // Known-answer flow
    access(0, 1, 8'h00, 3'b010, 32'h2b7e1516);
    access(0, 1, 8'h04, 3'b010, 32'h28aed2a6);
    access(0, 1, 8'h08, 3'b010, 32'habf71588);
    access(0, 1, 8'h0C, 3'b010, 32'h09cf4f3c);
    access(0, 1, 8'h20, 3'b010, 32'h3243f6a8);
    access(0, 1, 8'h24, 3'b010, 32'h885a308d);
    access(0, 1, 8'h28, 3'b010, 32'h313198a2);
    access(0, 1, 8'h2C, 3'b010, 32'he0370734);
    access(0, 1, 8'h30, 3'b010, 32'h1);
    chk_start("kat", 1'b1);
    chk("kat key", 256'(key4), exp_key(0));
    chk("kat pt", 256'(pt4), 256'(exp_pt(0)));
    access(0, 0, 8'h34, 3'b010, 32'h0);
    pulse_done(128'h196a0b32_dc118597_02dc09fb_3925841d);
    access(0, 0, 8'h34, 3'b010, 32'h0);
    for (int w = 0; w < 4; w++) access(0, 0, 8'h38 + 4 * w, 3'b010, 32'h0);

    // Interrupt enable, completion, W1C clear
    access(0, 1, 8'h30, 3'b010, 32'h3);
    chk_start("irq", 1'b1);
    pulse_done({$urandom, $urandom, $urandom, $urandom});
    access(0, 1, 8'h34, 3'b010, 32'h2);
    @(posedge HCLK); #1;
    chk("irq after w1c", 256'(irq4), 256'h0);
    access(0, 0, 8'h34, 3'b010, 32'h0);
    access(0, 0, 8'h30, 3'b010, 32'h0);

    // Writes rejected while busy
    k0 = m_key[0][0];
    access(0, 1, 8'h30, 3'b010, 32'h1);
    chk_start("busy", 1'b1);
    access(0, 1, 8'h00, 3'b010, $urandom);
    access(0, 1, 8'h30, 3'b010, 32'h1);
    chk_start("busy restart", 1'b0);
    access(0, 1, 8'h30, 3'b010, 32'h0);
    access(0, 0, 8'h00, 3'b010, 32'h0);
    chk("busy key0 kept", 256'(key4[31:0]), 256'(k0));
    pulse_done({$urandom, $urandom, $urandom, $urandom});
    access(0, 0, 8'h34, 3'b010, 32'h0);

    // Key-length boundaries, unmapped and bad-size accesses
    access(0, 0, 8'h10, 3'b010, 32'h0);
    access(0, 1, 8'h10, 3'b010, $urandom);
    access(1, 1, 8'h1C, 3'b010, 32'hDEADBEEF);
    access(1, 0, 8'h1C, 3'b010, 32'h0);
    access(0, 0, 8'h48, 3'b010, 32'h0);
    access(0, 1, 8'h00, 3'b000, $urandom);
    access(0, 0, 8'h00, 3'b010, 32'h0);
    access(0, 1, 8'h02, 3'b010, $urandom);
    access(0, 1, 8'h3C, 3'b010, $urandom);

    // Back-to-back write then read of TEXT0
    begin
      bit e; logic [31:0] er;
      v = $urandom;
      model_access(0, 1, 8'h20, 3'b010, v, e, er);
      model_access(0, 0, 8'h20, 3'b010, 32'h0, e, er);
      @(posedge HCLK); #1;
      sel8 = 1'b0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h20; hsize = 3'b010;
      @(posedge HCLK); #1;
      hwrite = 1'b0; hwdata = v;
      @(negedge HCLK);
      chk("pipe wr ready", {254'b0, bus4.HREADYOUT, bus4.HRESP}, 256'h2);
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge HCLK);
      chk("pipe rd data", 256'(bus4.HRDATA), 256'(er));
      chk("pipe rd ready", {254'b0, bus4.HREADYOUT, bus4.HRESP}, 256'h2);
    end

    // Randomized accesses to both instances
    for (int n = 0; n < 80; n++) begin
      int off;
      logic [2:0] sz;
      off = int'($urandom_range(0, 19)) * 4;
      if ($urandom_range(0, 7) == 0) off += int'($urandom_range(1, 3));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off, sz, $urandom);
      if ($urandom_range(0, 7) == 0) pulse_done({$urandom, $urandom, $urandom, $urandom});
    end
    @(posedge HCLK); #1;
    chk("rand key4", 256'(key4), exp_key(0));
    chk("rand key8", key8, exp_key(1));
    chk("rand pt", {pt8, pt4}, {exp_pt(1), exp_pt(0)});
    chk("rand irq", {254'b0, irq4, irq8},
        {254'b0, m_done[0] & m_irq_en[0], m_done[1] & m_irq_en[1]});

    // Reset while busy; a late completion must be ignored
    if (m_busy[0]) pulse_done({$urandom, $urandom, $urandom, $urandom});
    access(0, 1, 8'h30, 3'b010, 32'h3);
    chk_start("pre-reset", 1'b1);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    pulse_done({$urandom, $urandom, $urandom, $urandom});
    access(0, 0, 8'h34, 3'b010, 32'h0);
    access(0, 0, 8'h38, 3'b010, 32'h0);
    access(0, 0, 8'h00, 3'b010, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_ahb_regif.md
# aes_ahb_regif

Parametrised AHB-Lite slave register interface for the AES core, successor to the first-generation AES AHB interface. Adds proper address/data-phase pipelining, configurable key length (128/192/256), a busy/done control FSM with a single-cycle start pulse, ciphertext capture on completion, sticky W1C done status with interrupt, and two-cycle ERROR responses. Sits between the AHB interconnect and the AES core.

## Interface
- BASE_ADDR, 32'h4000_0000, slave base; only HADDR[7:0] decoded, upper bits ignored (HSEL qualifies)
- KEY_WORDS, 4, key length in 32-bit words; legal 4, 6, 8
- HCLK  in  1  AHB clock
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address
- HTRANS  in  2  transfer type; NONSEQ/SEQ when HTRANS[1]=1
- HWRITE  in  1  write/read
- HSIZE  in  3  transfer size; only 3'b010 legal
- HREADY  in  1  bus ready (previous data phase done)
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- irq  out  1  level interrupt = done & irq_en
- aes_key  out  32*KEY_WORDS  key, word 0 in LSBs
- aes_plaintext  out  128  plaintext, word 0 in LSBs
- aes_start  out  1  one-cycle start pulse
- aes_done  in  1  core completion pulse
- aes_ciphertext  in  128  core result, valid with aes_done

## Operation
- Map (offset): KEY0..KEY7 0x00–0x1C; TEXT0..3 0x20–0x2C; CTRL 0x30 (bit0 start W1 self-clearing, reads 0; bit1 irq_en R/W); STATUS 0x34 (bit0 busy RO, bit1 done sticky W1C); CIPH0..3 0x38–0x44 RO.
- Key words ≥ KEY_WORDS are invalid offsets.
- FSM: IDLE -> BUSY on accepted start write (aes_start pulses); BUSY -> IDLE on aes_done, capturing aes_ciphertext into CIPH regs and setting done. aes_done in IDLE ignored.
- ERROR (no state change) for: invalid or unaligned offset; HSIZE≠word; write to RO register; write to KEY/TEXT or start=1 while busy.
- Writing CTRL with start=0 while busy is OKAY (updates irq_en only).
- Done W1C and new capture in same cycle: set wins.
- Reads of KEY/TEXT return written values; unmapped reads are ERROR, HRDATA=0.

## Timing
- Address phase latched when HSEL & HREADY & HTRANS[1]; IDLE/BUSY HTRANS gives zero-wait OKAY, no effect.
- Writes: zero wait states; register updates at end of data phase (HWDATA sampled with HREADYOUT=1).
- Reads: zero wait states; HRDATA driven combinationally from registered address during data phase, 0 otherwise.
- ERROR: data-phase cycle 1 HREADYOUT=0,HRESP=1; cycle 2 HREADYOUT=1,HRESP=1.
- aes_start and busy asserted in the cycle after start write data phase; aes_key/aes_plaintext stable from then until done.
- done and irq assert the cycle after aes_done sampled.
- Reset values: HRDATA 0, HREADYOUT 1, HRESP 0, irq 0, aes_start 0, aes_key 0, aes_plaintext 0, all registers 0, FSM IDLE.
- Reset mid-operation: FSM to IDLE, pending aes_done discarded.

## Structure
- Package aes_ahb_pkg: register offsets, STATUS/CTRL bit indices, FSM state enum, HTRANS/HRESP/HSIZE constants.
- One sub-module: aes_ahb_err_resp (two-cycle ERROR sequencer with HREADYOUT/HRESP).
- Register file, decode and FSM in the top.

## Test plan
- Write KEY0..3=0x2b7e1516/28aed2a6/abf71588/09cf4f3c, TEXT0..3, CTRL=1 -> aes_start one cycle, STATUS=0x1; aes_done with ciphertext 0x3925841d… -> STATUS=0x2, CIPH0..3 match.
- CTRL=0x3 then complete -> irq=1; write STATUS=0x2 -> irq=0, done=0.
- While busy, write KEY0 or CTRL=1 -> two-cycle ERROR, KEY0 unchanged, no second aes_start.
- KEY_WORDS=4: access 0x10 -> ERROR; KEY_WORDS=8: 0x1C read back 0xDEADBEEF.
- Read 0x48, HSIZE=byte write 0x00 -> ERROR, HRDATA=0; back-to-back pipelined write/read to same TEXT0 returns new value.
- HRESETn low while busy -> all outputs 0, HREADYOUT=1; later aes_done ignored, STATUS=0.
